// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared state type and opcode width for the ALU arbiter
package alu_arb_pkg;

  localparam int ALU_SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } alu_arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// rtl/alu_arbiter_rr_pick.sv - one-hot winner picker (rr_pick)
// ALU_ARB_RR_EN selects round-robin from last_i+1; otherwise lowest index wins.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
`ifdef ALU_ARB_RR_EN
  input  logic [IW-1:0]   last_i,
`endif
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);

  logic          found;
  logic [IW-1:0] pos;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = '0;
`ifdef ALU_ARB_RR_EN
    // Scan last_i+1 .. last_i+NREQ so the previous winner is considered last.
    for (int i = 1; i <= NREQ; i++) begin
      pos = IW'((int'(last_i) + i) % NREQ);
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
`else
    for (int i = 0; i < NREQ; i++) begin
      pos = IW'(i);
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
`endif
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one combinational alu between NREQ requesters
// ALU_ARB_RR_EN enables round-robin arbitration; default is fixed priority.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*N-1:0]         req_a,
  input  logic [NREQ*N-1:0]         req_b,
  input  logic [NREQ*ALU_SEL_W-1:0] req_sel,
  output logic [N-1:0]              alu_a,
  output logic [N-1:0]              alu_b,
  output logic [ALU_SEL_W-1:0]      alu_sel,
  input  logic [N-1:0]              alu_s,
  input  logic                      alu_co,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [N-1:0]              rsp_s,
  output logic                      rsp_co,
  output logic [IW-1:0]             rsp_id
);

  alu_arb_state_t         state_q, state_d;
  logic [N-1:0]           a_q, a_d, b_q, b_d, s_q, s_d;
  logic [ALU_SEL_W-1:0]   sel_q, sel_d;
  logic [IW-1:0]          id_q, id_d;
  logic                   co_q, co_d, valid_q, valid_d;
  logic [NREQ-1:0]        gnt;
  logic [IW-1:0]          gnt_idx;
`ifdef ALU_ARB_RR_EN
  logic [IW-1:0]          last_q, last_d;
`endif

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
`ifdef ALU_ARB_RR_EN
    .last_i (last_q),
`endif
    .req_i  (req_valid),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sel_d     = sel_q;
    id_d      = id_q;
    s_d       = s_q;
    co_d      = co_q;
    valid_d   = valid_q;
    req_ready = '0;
`ifdef ALU_ARB_RR_EN
    last_d    = last_q;
`endif
    case (state_q)
      IDLE: begin
        req_ready = gnt;
        // gnt is only ever set on a valid bit, so any grant is a transfer.
        if (|gnt) begin
          a_d     = req_a[gnt_idx*N +: N];
          b_d     = req_b[gnt_idx*N +: N];
          sel_d   = req_sel[gnt_idx*ALU_SEL_W +: ALU_SEL_W];
          id_d    = gnt_idx;
          state_d = EXEC;
`ifdef ALU_ARB_RR_EN
          last_d  = gnt_idx;
`endif
        end
      end
      EXEC: begin
        s_d     = alu_s;
        co_d    = alu_co;
        valid_d = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      id_q    <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      valid_q <= 1'b0;
`ifdef ALU_ARB_RR_EN
      last_q  <= IW'(NREQ - 1);
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      id_q    <= id_d;
      s_q     <= s_d;
      co_q    <= co_d;
      valid_q <= valid_d;
`ifdef ALU_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_sel   = sel_q;
  assign rsp_valid = valid_q;
  assign rsp_s     = s_q;
  assign rsp_co    = co_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed vector bench for alu_arbiter with an a+b ALU stub
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid, req_ready;
  logic [7:0] req_a, req_b;
  logic [5:0] req_sel;
  logic [3:0] alu_a, alu_b, alu_s, rsp_s;
  logic [2:0] alu_sel;
  logic       alu_co, rsp_valid, rsp_ready, rsp_co;
  logic [0:0] rsp_id;

  int total = 0;
  int bad   = 0;

  alu_arbiter #(.N(4), .NREQ(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_s(alu_s), .alu_co(alu_co),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_s(rsp_s), .rsp_co(rsp_co), .rsp_id(rsp_id)
  );

  assign {alu_co, alu_s} = {1'b0, alu_a} + {1'b0, alu_b};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  typedef struct {
    int         id;
    logic [3:0] a, b;
    logic [2:0] sel;
    logic [3:0] exp_s;
    logic       exp_co;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_op(input vec_t v);
    @(negedge clk);
    req_valid = 2'b00;
    req_valid[v.id] = 1'b1;
    req_a[v.id*4 +: 4] = v.a;
    req_b[v.id*4 +: 4] = v.b;
    req_sel[v.id*3 +: 3] = v.sel;
    #1 check("vec_grant", req_ready, 32'(1 << v.id));
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check("vec_exec_ready", req_ready, 0);
    check("vec_exec_valid", rsp_valid, 0);
    check("vec_alu_a", alu_a, v.a);
    check("vec_alu_b", alu_b, v.b);
    check("vec_alu_sel", alu_sel, v.sel);
    @(negedge clk);
    #1;
    check("vec_rsp_valid", rsp_valid, 1);
    check("vec_rsp_s", rsp_s, v.exp_s);
    check("vec_rsp_co", rsp_co, v.exp_co);
    check("vec_rsp_id", rsp_id, v.id);
    @(negedge clk);
    #1 check("vec_rsp_clear", rsp_valid, 0);
  endtask

  int         grants[8];
  int         ng, nr;
  logic [3:0] held_s;
  int         exp_order[4];

  initial begin
    vecs[0] = '{0, 4'd3,  4'd5,  3'b000, 4'b1000, 1'b0};
    vecs[1] = '{0, 4'hF,  4'h1,  3'b000, 4'b0000, 1'b1};
    vecs[2] = '{1, 4'h7,  4'h7,  3'b101, 4'hE,    1'b0};
    vecs[3] = '{1, 4'h9,  4'h8,  3'b111, 4'h1,    1'b1};
    vecs[4] = '{0, 4'hA,  4'hA,  3'b010, 4'h4,    1'b1};
    vecs[5] = '{1, 4'h0,  4'h0,  3'b011, 4'h0,    1'b0};
`ifdef ALU_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif

    req_valid = '0; req_a = '0; req_b = '0; req_sel = '0; rsp_ready = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_sel", alu_sel, 0);
    check("rst_rsp_s", rsp_s, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_req_ready", req_ready, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_op(vecs[i]);

    // contention: both requesters valid continuously
    do_reset();
    req_a = {4'd4, 4'd1}; req_b = {4'd4, 4'd2}; req_sel = '0;
    req_valid = 2'b11; rsp_ready = 1'b1;
    ng = 0; nr = 0;
    for (int c = 0; c < 40 && nr < 4; c++) begin
      @(negedge clk);
      #1;
      if (req_ready != 2'b00) begin
        check("cont_onehot", $countones(req_ready), 1);
        if (ng < 8) grants[ng] = (req_ready == 2'b10) ? 1 : 0;
        ng++;
      end
      if (rsp_valid) begin
        check("cont_rsp_id", rsp_id, grants[nr]);
        check("cont_rsp_s", rsp_s, (grants[nr] == 1) ? 8 : 3);
        nr++;
      end
    end
    req_valid = 2'b00;
    if (nr < 4) check("cont_timeout", nr, 4);
    for (int k = 0; k < 4; k++) check("cont_order", grants[k], exp_order[k]);

    // backpressure
    do_reset();
    @(negedge clk);
    req_valid = 2'b01; req_a = {4'd6, 4'd2}; req_b = {4'd1, 4'd3}; rsp_ready = 1'b0;
    #1 check("bp_grant0", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b10;
    #1 check("bp_exec_ready", req_ready, 0);
    @(negedge clk);
    #1;
    check("bp_rsp_valid", rsp_valid, 1);
    check("bp_rsp_s", rsp_s, 5);
    held_s = rsp_s;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_s", rsp_s, held_s);
      check("bp_hold_id", rsp_id, 0);
      check("bp_hold_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_release_valid", rsp_valid, 0);
    check("bp_next_grant", req_ready, 2'b10);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    check("bp_second_s", rsp_s, 7);
    check("bp_second_id", rsp_id, 1);

    // withdrawn request during RESP
    do_reset();
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 2'b01; req_a = {4'd6, 4'd1}; req_b = {4'd1, 4'd1};
    #1 check("wd_grant0", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    req_valid = 2'b10;
    #1 check("wd_pulse_ready", req_ready, 0);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check("wd_rsp_valid", rsp_valid, 1);
    check("wd_rsp_id", rsp_id, 0);
    check("wd_rsp_s", rsp_s, 2);
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("wd_idle_valid", rsp_valid, 0);
    check("wd_idle_ready", req_ready, 0);

    // reset during EXEC
    do_reset();
    @(negedge clk);
    req_valid = 2'b10; req_a = {4'd5, 4'd0}; req_b = {4'd6, 4'd0}; req_sel = {3'd3, 3'd0};
    @(negedge clk);
    req_valid = 2'b00;
    #1 check("rx_exec_alu_a", alu_a, 5);
    check("rx_exec_alu_sel", alu_sel, 3);
    rst_n = 1'b0;
    #1;
    check("rx_rsp_valid", rsp_valid, 0);
    check("rx_alu_a", alu_a, 0);
    check("rx_alu_b", alu_b, 0);
    check("rx_alu_sel", alu_sel, 0);
    @(negedge clk);
    req_valid = 2'b11;
    rst_n = 1'b1;
    #1 check("rx_first_grant", req_ready, 2'b01);
    req_valid = 2'b00;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
